// File: rtl/arb_event_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : arb_event_sequencer
//  Brief    : Frame controller for one arbiter level. Enables the arbiter,
//             captures each granted (x,y) with a timestamp into a show-ahead
//             event FIFO, paces group-enable against FIFO space and detects
//             end of frame (group release or idle timeout).
//  Revision : 1.0  initial release
// ============================================================================
module arb_event_sequencer #(
  parameter int Lvl_ADD      = 1,
  parameter int TS_WIDTH     = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int IDLE_TIMEOUT = 8
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          start_i,
  input  logic                          abort_i,
  input  logic                          arb_req_i,
  input  logic                          arb_active_i,
  input  logic [Lvl_ADD-1:0]            arb_x_add_i,
  input  logic [Lvl_ADD-1:0]            arb_y_add_i,
  input  logic                          arb_grp_release_i,
  output logic                          arb_enable_o,
  output logic                          grp_enable_o,
  output logic                          evt_valid_o,
  input  logic                          evt_ready_i,
  output logic [2*Lvl_ADD+TS_WIDTH-1:0] evt_data_o,
  output logic                          busy_o,
  output logic                          frame_done_o,
  output logic [15:0]                   evt_count_o,
  output logic                          stall_o
);

  localparam int DATA_W = 2*Lvl_ADD + TS_WIDTH;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARB     = 3'd1,
    S_ADVANCE = 3'd2,
    S_SETTLE  = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic [15:0]         evt_count_q, evt_count_d;
  logic                arb_enable_q, arb_enable_d;
  logic                grp_enable_q, grp_enable_d;
  logic                busy_q, busy_d;
  logic                frame_done_q, frame_done_d;
  logic                stall_q, stall_d;

  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0]   mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    fifo_cnt_q, fifo_cnt_d;

  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_push;
  logic                fifo_pop;
  logic [DATA_W-1:0]   push_data;

  assign fifo_full  = (fifo_cnt_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt_q == '0);
  assign fifo_pop   = !fifo_empty && evt_ready_i;
  assign push_data  = {arb_x_add_i, arb_y_add_i, ts_q};

  // Free-running timestamp, wraps naturally from all-ones to zero.
  always_comb begin
    ts_d = ts_q + 1'b1;
  end

  // Frame sequencing: next state, capture decision and registered-output values.
  always_comb begin
    state_d     = state_q;
    idle_d      = idle_q;
    evt_count_d = evt_count_q;
    fifo_push   = 1'b0;
    stall_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d     = S_ARB;
          evt_count_d = '0;
          idle_d      = '0;
        end
      end
      S_ARB: begin
        if (arb_req_i || arb_active_i) begin
          idle_d = '0;
        end else if (idle_q != IDLE_W'(IDLE_TIMEOUT)) begin
          idle_d = idle_q + 1'b1;
        end

        if (arb_grp_release_i) begin
          state_d = S_DONE;
        end else if (arb_active_i && !fifo_full) begin
          fifo_push = 1'b1;
          if (evt_count_q != 16'hFFFF) begin
            evt_count_d = evt_count_q + 16'd1;
          end
          state_d = S_ADVANCE;
        end else if (arb_active_i) begin
          // Still blocked next cycle unless a pop frees a slot this cycle.
          stall_d = !fifo_pop;
        end else if (idle_q == IDLE_W'(IDLE_TIMEOUT)) begin
          state_d = S_DONE;
        end
      end
      S_ADVANCE: state_d = S_SETTLE;
      S_SETTLE:  state_d = S_ARB;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    // Abort wins over everything; the frame is dropped without a done pulse.
    if (abort_i && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      fifo_push   = 1'b0;
      stall_d     = 1'b0;
      evt_count_d = evt_count_q;
    end

    arb_enable_d = (state_d == S_ARB) || (state_d == S_ADVANCE) || (state_d == S_SETTLE);
    grp_enable_d = (state_d == S_ADVANCE);
    frame_done_d = (state_d == S_DONE);
    busy_d       = (state_d != S_IDLE);
  end

  // Event FIFO bookkeeping: write at tail, read at head, occupancy count.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (fifo_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (fifo_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({fifo_push, fifo_pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // State, outputs, timestamp and FIFO storage registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      ts_q         <= '0;
      idle_q       <= '0;
      evt_count_q  <= '0;
      arb_enable_q <= 1'b0;
      grp_enable_q <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      stall_q      <= 1'b0;
      mem_q        <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      ts_q         <= ts_d;
      idle_q       <= idle_d;
      evt_count_q  <= evt_count_d;
      arb_enable_q <= arb_enable_d;
      grp_enable_q <= grp_enable_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      stall_q      <= stall_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
    end
  end

  assign arb_enable_o = arb_enable_q;
  assign grp_enable_o = grp_enable_q;
  assign busy_o       = busy_q;
  assign frame_done_o = frame_done_q;
  assign stall_o      = stall_q;
  assign evt_count_o  = evt_count_q;
  assign evt_valid_o  = !fifo_empty;
  assign evt_data_o   = fifo_empty ? '0 : mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: tb/tb_arb_event_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_arb_event_sequencer
//  Brief    : Directed bench for arb_event_sequencer with a small arbiter
//             model (grant list advanced by grp_enable_o).
//  Revision : 1.0  initial release
// ============================================================================
module tb_arb_event_sequencer;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic        arb_req_i;
  logic        arb_active_i;
  logic [0:0]  arb_x_add_i;
  logic [0:0]  arb_y_add_i;
  logic        arb_grp_release_i;
  logic        arb_enable_o;
  logic        grp_enable_o;
  logic        evt_valid_o;
  logic        evt_ready_i = 1'b0;
  logic [17:0] evt_data_o;
  logic        busy_o;
  logic        frame_done_o;
  logic [15:0] evt_count_o;
  logic        stall_o;

  arb_event_sequencer dut (
    .clk_i             (clk),
    .reset_i           (reset_i),
    .start_i           (start_i),
    .abort_i           (abort_i),
    .arb_req_i         (arb_req_i),
    .arb_active_i      (arb_active_i),
    .arb_x_add_i       (arb_x_add_i),
    .arb_y_add_i       (arb_y_add_i),
    .arb_grp_release_i (arb_grp_release_i),
    .arb_enable_o      (arb_enable_o),
    .grp_enable_o      (grp_enable_o),
    .evt_valid_o       (evt_valid_o),
    .evt_ready_i       (evt_ready_i),
    .evt_data_o        (evt_data_o),
    .busy_o            (busy_o),
    .frame_done_o      (frame_done_o),
    .evt_count_o       (evt_count_o),
    .stall_o           (stall_o)
  );

  always #5 clk = ~clk;

  // Arbiter model: pending grants q_head..q_tail-1, head advanced by grp_enable_o.
  logic [0:0] pend_x [0:63];
  logic [0:0] pend_y [0:63];
  int         q_head = 0;
  int         q_tail = 0;
  logic       rel_en = 1'b0;

  assign arb_active_i      = (q_head != q_tail);
  assign arb_req_i         = (q_head != q_tail);
  assign arb_x_add_i       = pend_x[q_head];
  assign arb_y_add_i       = pend_y[q_head];
  assign arb_grp_release_i = rel_en && (q_head == q_tail);

  always @(posedge clk) begin
    if (grp_enable_o && (q_head != q_tail)) q_head <= q_head + 1;
  end

  // Cycle counter and reference timestamp.
  int          cyc = 0;
  logic [15:0] m_ts = 16'd0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset_i) m_ts <= 16'd0;
    else         m_ts <= m_ts + 16'd1;
  end

  // Observation: delivered events, grp_enable pulses, frame_done pulses.
  logic [17:0] rx_data [0:63];
  int          rx_n = 0;
  int          gp_cyc [0:63];
  int          gp_n = 0;
  int          fd_cyc = 0;
  int          fd_n = 0;
  always @(negedge clk) begin
    if (evt_valid_o && evt_ready_i) begin
      rx_data[rx_n] = evt_data_o;
      rx_n = rx_n + 1;
    end
    if (grp_enable_o) begin
      gp_cyc[gp_n] = cyc;
      gp_n = gp_n + 1;
    end
    if (frame_done_o) begin
      fd_cyc = cyc;
      fd_n = fd_n + 1;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic load_grant(input logic x, input logic y);
    pend_x[q_tail] = x;
    pend_y[q_tail] = y;
    q_tail = q_tail + 1;
  endtask

  int          rx_base, gp_base, fd_base;
  logic [15:0] s_ts, r_ts;
  int          s_cyc;

  task automatic mark();
    rx_base = rx_n;
    gp_base = gp_n;
    fd_base = fd_n;
  endtask

  // Pulse start for one cycle; returns in the first ARB cycle.
  task automatic pulse_start();
    next_cycle();
    start_i = 1'b1;
    s_ts    = m_ts;
    s_cyc   = cyc;
    next_cycle();
    start_i = 1'b0;
  endtask

  task automatic wait_frame(input int cap);
    for (int i = 0; i < cap && fd_n == fd_base; i++) next_cycle();
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && (evt_valid_o || busy_o); i++) next_cycle();
    next_cycle();
  endtask

  initial begin
    // ---------------- reset state ----------------
    repeat (3) next_cycle();
    reset_i = 1'b0;
    @(negedge clk);
    check("rst_arb_en",  32'(arb_enable_o), 32'd0);
    check("rst_grp_en",  32'(grp_enable_o), 32'd0);
    check("rst_busy",    32'(busy_o),       32'd0);
    check("rst_done",    32'(frame_done_o), 32'd0);
    check("rst_stall",   32'(stall_o),      32'd0);
    check("rst_count",   32'(evt_count_o),  32'd0);
    check("rst_valid",   32'(evt_valid_o),  32'd0);
    check("rst_data",    32'(evt_data_o),   32'd0);

    // ---------------- two grants, free-flowing readout ----------------
    load_grant(1'b0, 1'b1);
    load_grant(1'b1, 1'b0);
    rel_en = 1'b1;
    evt_ready_i = 1'b1;
    mark();
    pulse_start();
    @(negedge clk);
    check("t1_arb_en", 32'(arb_enable_o), 32'd1);
    check("t1_busy",   32'(busy_o),       32'd1);
    wait_frame(50);
    wait_drain();
    check("t1_nevt",   32'(rx_n - rx_base), 32'd2);
    check("t1_evt0",   32'(rx_data[rx_base]),   32'({1'b0, 1'b1, 16'(s_ts + 16'd1)}));
    check("t1_evt1",   32'(rx_data[rx_base+1]), 32'({1'b1, 1'b0, 16'(s_ts + 16'd4)}));
    check("t1_ngrp",   32'(gp_n - gp_base), 32'd2);
    check("t1_gap",    32'(gp_cyc[gp_base+1] - gp_cyc[gp_base]), 32'd3);
    check("t1_ndone",  32'(fd_n - fd_base), 32'd1);
    check("t1_done_t", 32'(fd_cyc - s_cyc), 32'd8);
    check("t1_count",  32'(evt_count_o), 32'd2);
    check("t1_idle",   32'(busy_o), 32'd0);

    // ---------------- six grants against a full FIFO ----------------
    rel_en = 1'b0;
    evt_ready_i = 1'b0;
    load_grant(1'b0, 1'b0);
    load_grant(1'b0, 1'b1);
    load_grant(1'b1, 1'b0);
    load_grant(1'b1, 1'b1);
    load_grant(1'b1, 1'b0);
    load_grant(1'b0, 1'b1);
    rel_en = 1'b1;
    mark();
    pulse_start();
    repeat (15) next_cycle();
    @(negedge clk);
    check("t2_stall",  32'(stall_o),      32'd1);
    check("t2_grp_lo", 32'(grp_enable_o), 32'd0);
    check("t2_count4", 32'(evt_count_o),  32'd4);
    check("t2_ngrp4",  32'(gp_n - gp_base), 32'd4);
    next_cycle();
    evt_ready_i = 1'b1;
    r_ts = m_ts;
    @(negedge clk);
    check("t2_stall_pop",  32'(stall_o), 32'd1);
    next_cycle();
    @(negedge clk);
    check("t2_stall_clr",  32'(stall_o), 32'd0);
    wait_frame(60);
    wait_drain();
    check("t2_nevt",  32'(rx_n - rx_base), 32'd6);
    check("t2_evt0",  32'(rx_data[rx_base]),   32'({1'b0, 1'b0, 16'(s_ts + 16'd1)}));
    check("t2_evt1",  32'(rx_data[rx_base+1]), 32'({1'b0, 1'b1, 16'(s_ts + 16'd4)}));
    check("t2_evt2",  32'(rx_data[rx_base+2]), 32'({1'b1, 1'b0, 16'(s_ts + 16'd7)}));
    check("t2_evt3",  32'(rx_data[rx_base+3]), 32'({1'b1, 1'b1, 16'(s_ts + 16'd10)}));
    check("t2_evt4",  32'(rx_data[rx_base+4]), 32'({1'b1, 1'b0, 16'(r_ts + 16'd1)}));
    check("t2_evt5",  32'(rx_data[rx_base+5]), 32'({1'b0, 1'b1, 16'(r_ts + 16'd4)}));
    check("t2_ngrp",  32'(gp_n - gp_base), 32'd6);
    check("t2_count", 32'(evt_count_o), 32'd6);
    check("t2_ndone", 32'(fd_n - fd_base), 32'd1);

    // ---------------- empty frame: idle timeout ----------------
    rel_en = 1'b0;
    mark();
    pulse_start();
    wait_frame(40);
    next_cycle();
    check("t3_ndone",  32'(fd_n - fd_base), 32'd1);
    check("t3_done_t", 32'(fd_cyc - s_cyc), 32'd10);
    check("t3_count",  32'(evt_count_o), 32'd0);
    check("t3_nevt",   32'(rx_n - rx_base), 32'd0);
    check("t3_ngrp",   32'(gp_n - gp_base), 32'd0);

    // ---------------- abort in ADVANCE with two events buffered ----------------
    evt_ready_i = 1'b0;
    load_grant(1'b1, 1'b1);
    load_grant(1'b0, 1'b0);
    load_grant(1'b1, 1'b0);
    mark();
    pulse_start();
    repeat (4) next_cycle();
    abort_i = 1'b1;
    @(negedge clk);
    check("t4_in_adv", 32'(grp_enable_o), 32'd1);
    next_cycle();
    abort_i = 1'b0;
    q_tail = q_head;
    @(negedge clk);
    check("t4_arb_en", 32'(arb_enable_o), 32'd0);
    check("t4_grp_en", 32'(grp_enable_o), 32'd0);
    check("t4_busy",   32'(busy_o),       32'd0);
    check("t4_valid",  32'(evt_valid_o),  32'd1);
    repeat (10) next_cycle();
    check("t4_nodone", 32'(fd_n - fd_base), 32'd0);
    evt_ready_i = 1'b1;
    wait_drain();
    check("t4_nevt",  32'(rx_n - rx_base), 32'd2);
    check("t4_evt0",  32'(rx_data[rx_base]),   32'({1'b1, 1'b1, 16'(s_ts + 16'd1)}));
    check("t4_evt1",  32'(rx_data[rx_base+1]), 32'({1'b0, 1'b0, 16'(s_ts + 16'd4)}));

    // ---------------- reset mid-frame with three events buffered ----------------
    evt_ready_i = 1'b0;
    load_grant(1'b0, 1'b1);
    load_grant(1'b1, 1'b0);
    load_grant(1'b1, 1'b1);
    load_grant(1'b0, 1'b0);
    mark();
    pulse_start();
    repeat (7) next_cycle();
    @(negedge clk);
    check("t6_pre_cnt", 32'(evt_count_o), 32'd3);
    next_cycle();
    reset_i = 1'b1;
    next_cycle();
    reset_i = 1'b0;
    q_tail = q_head;
    @(negedge clk);
    check("t6_arb_en", 32'(arb_enable_o), 32'd0);
    check("t6_grp_en", 32'(grp_enable_o), 32'd0);
    check("t6_busy",   32'(busy_o),       32'd0);
    check("t6_done",   32'(frame_done_o), 32'd0);
    check("t6_stall",  32'(stall_o),      32'd0);
    check("t6_count",  32'(evt_count_o),  32'd0);
    check("t6_valid",  32'(evt_valid_o),  32'd0);
    check("t6_data",   32'(evt_data_o),   32'd0);
    // one capture after reset exposes the restarted timestamp
    evt_ready_i = 1'b1;
    rel_en = 1'b1;
    load_grant(1'b1, 1'b0);
    mark();
    pulse_start();
    wait_frame(30);
    wait_drain();
    check("t6_nevt", 32'(rx_n - rx_base), 32'd1);
    check("t6_ts",   32'(rx_data[rx_base]), 32'({1'b1, 1'b0, 16'(s_ts + 16'd1)}));

    // ---------------- timestamp wrap ----------------
    for (int i = 0; i < 70000 && m_ts != 16'hFFFE; i++) next_cycle();
    check("t5_reach", 32'(m_ts), 32'h0000FFFE);
    load_grant(1'b0, 1'b1);
    mark();
    next_cycle();
    pulse_start();
    wait_frame(30);
    wait_drain();
    check("t5_nevt", 32'(rx_n - rx_base), 32'd1);
    check("t5_wrap", 32'(rx_data[rx_base]), 32'({1'b0, 1'b1, 16'h0001}));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
